swim_entry_sequencer: RTL

//  Sequences the STM8 SWIM entry pattern on the debug connector: asserts target reset,

---
 rtl/swim_entry_sequencer_pkg.sv | 69 ++++++
 rtl/swim_entry_sequencer_if.sv | 26 ++
 rtl/swim_timer.sv | 30 +++
 rtl/swim_entry_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/swim_entry_sequencer_pkg.sv
// Shared types, widths and default timings for the STM8 SWIM entry sequencer.
// The per-state output decode lives here so the sequencer and anything that
// inspects its state agree on which pads each state drives.
package swim_pkg;

    localparam int TIMER_W   = 20;
    localparam int PULSE_W   = 3;
    localparam int ATTEMPT_W = 3;
    localparam int WIDTH_W   = 20;

    localparam int DEF_T_RST     = 1600;
    localparam int DEF_T_INIT    = 400;
    localparam int DEF_HALF_1K   = 12000;
    localparam int DEF_HALF_2K   = 6000;
    localparam int DEF_N_PULSE   = 4;
    localparam int DEF_SYNC_TOUT = 4000;
    localparam int DEF_SYNC_MIN  = 300;
    localparam int DEF_SYNC_MAX  = 500;
    localparam int DEF_RETRY_GAP = 2000;
    localparam int DEF_MAX_RETRY = 2;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RST   = 4'd1,
        ST_INIT  = 4'd2,
        ST_P1L   = 4'd3,
        ST_P1H   = 4'd4,
        ST_P2L   = 4'd5,
        ST_P2H   = 4'd6,
        ST_WSYNC = 4'd7,
        ST_MSYNC = 4'd8,
        ST_GAP   = 4'd9,
        ST_READY = 4'd10,
        ST_FAIL  = 4'd11
    } state_t;

    // States that pull the SWIM pad low.
    function automatic logic swim_low_of(input state_t s);
        case (s)
            ST_INIT, ST_P1L, ST_P2L: swim_low_of = 1'b1;
            default:                 swim_low_of = 1'b0;
        endcase
    endfunction

    // Target reset is held from the first reset phase until READY is released.
    function automatic logic rst_line_of(input state_t s);
        case (s)
            ST_IDLE, ST_FAIL: rst_line_of = 1'b0;
            default:          rst_line_of = 1'b1;
        endcase
    endfunction

    function automatic logic busy_of(input state_t s);
        case (s)
            ST_IDLE, ST_READY, ST_FAIL: busy_of = 1'b0;
            default:                    busy_of = 1'b1;
        endcase
    endfunction

    // States whose duration (or timeout) is governed by the shared timer.
    function automatic logic timed_of(input state_t s);
        case (s)
            ST_RST, ST_INIT, ST_P1L, ST_P1H, ST_P2L, ST_P2H, ST_WSYNC, ST_GAP:
                     timed_of = 1'b1;
            default: timed_of = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/swim_entry_sequencer_if.sv
// Host/pad bundle of the SWIM entry sequencer. The master side is the host
// command logic plus the pad sampler; the slave side is the sequencer.
interface swim_entry_sequencer_if;

    logic                           start;
    logic                           abort;
    logic                           release_req;
    logic                           swim_in;
    logic                           swim_low;
    logic                           rst_line;
    logic                           busy;
    logic                           done;
    logic                           fail;
    logic [swim_pkg::ATTEMPT_W-1:0] attempt;

    modport master (
        output start, abort, release_req, swim_in,
        input  swim_low, rst_line, busy, done, fail, attempt
    );

    modport slave (
        input  start, abort, release_req, swim_in,
        output swim_low, rst_line, busy, done, fail, attempt
    );

endinterface

// File: rtl/swim_timer.sv
// Shared down-counter for every timed sequencer state. After a load of N the
// expired pulse is seen on the N-th following clock edge, so a state that
// reloads on entry and leaves on expired lasts exactly N cycles.
module swim_timer
    import swim_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [TIMER_W-1:0] value,
    output logic               expired
);

    logic [TIMER_W-1:0] count_reg;

    // Clear dominates load; count stops at zero so expired fires once.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - TIMER_W'(1);
        end
    end

    assign expired = (count_reg == TIMER_W'(1));

endmodule

// File: rtl/swim_entry_sequencer.sv
// STM8 SWIM entry sequencer: holds target reset, drives the 4 x 1 kHz and
// 4 x 2 kHz low-pulse train on SWIM, then measures the target's sync pulse.
// Failed attempts retry after a released-SWIM gap with reset still held.
// All outputs are registered from the next state, so they change on the same
// edge that enters a state.
module swim_entry_sequencer
    import swim_pkg::*;
#(
    parameter int T_RST     = DEF_T_RST,
    parameter int T_INIT    = DEF_T_INIT,
    parameter int HALF_1K   = DEF_HALF_1K,
    parameter int HALF_2K   = DEF_HALF_2K,
    parameter int N_PULSE   = DEF_N_PULSE,
    parameter int SYNC_TOUT = DEF_SYNC_TOUT,
    parameter int SYNC_MIN  = DEF_SYNC_MIN,
    parameter int SYNC_MAX  = DEF_SYNC_MAX,
    parameter int RETRY_GAP = DEF_RETRY_GAP,
    parameter int MAX_RETRY = DEF_MAX_RETRY
)(
    input  logic                  clk,
    input  logic                  reset,
    swim_entry_sequencer_if.slave bus
);

    localparam logic [TIMER_W-1:0]   LD_RST     = TIMER_W'(T_RST);
    localparam logic [TIMER_W-1:0]   LD_INIT    = TIMER_W'(T_INIT);
    localparam logic [TIMER_W-1:0]   LD_1K      = TIMER_W'(HALF_1K);
    localparam logic [TIMER_W-1:0]   LD_2K      = TIMER_W'(HALF_2K);
    localparam logic [TIMER_W-1:0]   LD_TOUT    = TIMER_W'(SYNC_TOUT);
    localparam logic [TIMER_W-1:0]   LD_GAP     = TIMER_W'(RETRY_GAP);
    localparam logic [WIDTH_W-1:0]   WIDTH_MIN  = WIDTH_W'(SYNC_MIN);
    localparam logic [WIDTH_W-1:0]   WIDTH_MAX  = WIDTH_W'(SYNC_MAX);
    localparam logic [PULSE_W-1:0]   LAST_PULSE = PULSE_W'(N_PULSE - 1);
    localparam logic [ATTEMPT_W-1:0] RETRY_LIM  = ATTEMPT_W'(MAX_RETRY);

    state_t               state_reg, state_next;
    logic [PULSE_W-1:0]   pulse_reg, pulse_next;
    logic [ATTEMPT_W-1:0] attempt_reg, attempt_next;
    logic [WIDTH_W-1:0]   width_reg, width_next;
    logic                 retry;

    logic                 swim_low_reg, rst_line_reg, busy_reg, done_reg, fail_reg;

    logic                 tmr_load, tmr_clear, tmr_expired;
    logic [TIMER_W-1:0]   tmr_value;

    swim_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .clear   (tmr_clear),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

    // Next-state logic for the sequencer and its pulse/attempt/width counters.
    always_comb begin
        state_next   = state_reg;
        pulse_next   = pulse_reg;
        attempt_next = attempt_reg;
        width_next   = width_reg;
        retry        = 1'b0;

        case (state_reg)
            ST_IDLE, ST_READY, ST_FAIL: begin
                if (bus.start) begin
                    state_next   = ST_RST;
                    attempt_next = '0;
                end else if (state_reg == ST_READY && bus.release_req) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RST:  if (tmr_expired) state_next = ST_INIT;
            ST_INIT: begin
                if (tmr_expired) begin
                    state_next = ST_P1L;
                    pulse_next = '0;
                end
            end
            ST_P1L:  if (tmr_expired) state_next = ST_P1H;
            ST_P1H: begin
                if (tmr_expired) begin
                    if (pulse_reg == LAST_PULSE) begin
                        state_next = ST_P2L;
                        pulse_next = '0;
                    end else begin
                        state_next = ST_P1L;
                        pulse_next = pulse_reg + PULSE_W'(1);
                    end
                end
            end
            ST_P2L:  if (tmr_expired) state_next = ST_P2H;
            ST_P2H: begin
                if (tmr_expired) begin
                    if (pulse_reg == LAST_PULSE) begin
                        state_next = ST_WSYNC;
                        pulse_next = '0;
                    end else begin
                        state_next = ST_P2L;
                        pulse_next = pulse_reg + PULSE_W'(1);
                    end
                end
            end
            ST_WSYNC: begin
                // The falling edge itself is the first counted low cycle.
                if (!bus.swim_in) begin
                    state_next = ST_MSYNC;
                    width_next = WIDTH_W'(1);
                end else if (tmr_expired) begin
                    retry = 1'b1;
                end
            end
            ST_MSYNC: begin
                if (!bus.swim_in) begin
                    // This cycle would make the pulse too wide: give up now.
                    if (width_reg >= WIDTH_MAX) begin
                        retry = 1'b1;
                    end else if (width_reg != '1) begin
                        width_next = width_reg + WIDTH_W'(1);
                    end
                end else if (width_reg >= WIDTH_MIN && width_reg <= WIDTH_MAX) begin
                    state_next = ST_READY;
                end else begin
                    retry = 1'b1;
                end
            end
            ST_GAP:  if (tmr_expired) state_next = ST_INIT;
            default: state_next = ST_IDLE;
        endcase

        if (retry) begin
            if (attempt_reg < RETRY_LIM) begin
                state_next   = ST_GAP;
                attempt_next = attempt_reg + ATTEMPT_W'(1);
            end else begin
                state_next = ST_FAIL;
            end
        end

        if (bus.abort) begin
            state_next   = ST_IDLE;
            pulse_next   = '0;
            attempt_next = '0;
            width_next   = '0;
        end
    end

    // Timer is reloaded on entry to any timed state and held clear elsewhere.
    always_comb begin
        tmr_clear = !timed_of(state_next);
        tmr_load  = timed_of(state_next) && (state_next != state_reg);
        case (state_next)
            ST_RST:          tmr_value = LD_RST;
            ST_INIT:         tmr_value = LD_INIT;
            ST_P1L, ST_P1H:  tmr_value = LD_1K;
            ST_P2L, ST_P2H:  tmr_value = LD_2K;
            ST_WSYNC:        tmr_value = LD_TOUT;
            ST_GAP:          tmr_value = LD_GAP;
            default:         tmr_value = '0;
        endcase
    end

    // State, counters and the output registers decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            pulse_reg    <= '0;
            attempt_reg  <= '0;
            width_reg    <= '0;
            swim_low_reg <= 1'b0;
            rst_line_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            fail_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pulse_reg    <= pulse_next;
            attempt_reg  <= attempt_next;
            width_reg    <= width_next;
            swim_low_reg <= swim_low_of(state_next);
            rst_line_reg <= rst_line_of(state_next);
            busy_reg     <= busy_of(state_next);
            done_reg     <= (state_next == ST_READY);
            fail_reg     <= (state_next == ST_FAIL);
        end
    end

    assign bus.swim_low = swim_low_reg;
    assign bus.rst_line = rst_line_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.fail     = fail_reg;
    assign bus.attempt  = attempt_reg;

endmodule
